// File: rtl/conv_pkg.sv
// Shared types for the modport_dut 3x3 convolution engine: configuration record,
// controller state encoding and the result saturation helper.
package conv_pkg;

    typedef struct packed {
        int unsigned data_width;
        int unsigned accumulation_width;
        int unsigned feature_map_width;
        int unsigned feature_map_height;
        int unsigned input_nb_channels;
        int unsigned output_nb_channels;
        int unsigned kernel_size;
        int unsigned output_shift;
    } config_t;

    localparam config_t DEFAULT_CFG = '{
        data_width:         32'd16,
        accumulation_width: 32'd32,
        feature_map_width:  32'd4,
        feature_map_height: 32'd4,
        input_nb_channels:  32'd2,
        output_nb_channels: 32'd4,
        kernel_size:        32'd3,
        output_shift:       32'd0
    };

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_W  = 3'd1,
        LOAD_A  = 3'd2,
        COMPUTE = 3'd3,
        OUT     = 3'd4
    } state_t;

    // Clamp a signed value into the range of a signed w-bit number (w <= 64).
    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v,
                                                      input int unsigned w);
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        max_v = (64'sd1 <<< (w - 32'd1)) - 64'sd1;
        min_v = -max_v - 64'sd1;
        if (v > max_v) begin
            sat_signed = max_v;
        end else if (v < min_v) begin
            sat_signed = min_v;
        end else begin
            sat_signed = v;
        end
    endfunction

endpackage

// File: rtl/mac3.sv
// Three signed multipliers feeding one accumulator; clear has priority over enable.
module mac3 #(
    parameter int DATA_WIDTH         = 16,
    parameter int ACCUMULATION_WIDTH = 32
) (
    input  logic                                 clk,
    input  logic                                 arst_n,
    input  logic                                 clr,
    input  logic                                 en,
    input  logic signed [DATA_WIDTH-1:0]         w0,
    input  logic signed [DATA_WIDTH-1:0]         w1,
    input  logic signed [DATA_WIDTH-1:0]         w2,
    input  logic signed [DATA_WIDTH-1:0]         a0,
    input  logic signed [DATA_WIDTH-1:0]         a1,
    input  logic signed [DATA_WIDTH-1:0]         a2,
    output logic signed [ACCUMULATION_WIDTH-1:0] acc
);

    logic signed [2*DATA_WIDTH-1:0]       m0_s;
    logic signed [2*DATA_WIDTH-1:0]       m1_s;
    logic signed [2*DATA_WIDTH-1:0]       m2_s;
    logic signed [ACCUMULATION_WIDTH-1:0] sum_s;
    logic signed [ACCUMULATION_WIDTH-1:0] acc_d;
    logic signed [ACCUMULATION_WIDTH-1:0] acc_q;

    assign m0_s = $signed({{DATA_WIDTH{w0[DATA_WIDTH-1]}}, w0}) * $signed({{DATA_WIDTH{a0[DATA_WIDTH-1]}}, a0});
    assign m1_s = $signed({{DATA_WIDTH{w1[DATA_WIDTH-1]}}, w1}) * $signed({{DATA_WIDTH{a1[DATA_WIDTH-1]}}, a1});
    assign m2_s = $signed({{DATA_WIDTH{w2[DATA_WIDTH-1]}}, w2}) * $signed({{DATA_WIDTH{a2[DATA_WIDTH-1]}}, a2});

    // Row sum of sign-extended products and next accumulator value (wraps on overflow).
    always_comb begin
        sum_s = ACCUMULATION_WIDTH'(m0_s) + ACCUMULATION_WIDTH'(m1_s) + ACCUMULATION_WIDTH'(m2_s);
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q + sum_s;
        end else begin
            acc_d = acc_q;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/modport_dut.sv
// Streaming 3x3 convolution engine over three shared tristate buses.
// Build option: define RELU_EN to clamp negative results to zero.
module modport_dut
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH         = int'(DEFAULT_CFG.data_width),
    parameter int ACCUMULATION_WIDTH = int'(DEFAULT_CFG.accumulation_width),
    parameter int FEATURE_MAP_WIDTH  = int'(DEFAULT_CFG.feature_map_width),
    parameter int FEATURE_MAP_HEIGHT = int'(DEFAULT_CFG.feature_map_height),
    parameter int INPUT_NB_CHANNELS  = int'(DEFAULT_CFG.input_nb_channels),
    parameter int OUTPUT_NB_CHANNELS = int'(DEFAULT_CFG.output_nb_channels),
    parameter int KERNEL_SIZE        = int'(DEFAULT_CFG.kernel_size),
    parameter int OUTPUT_SHIFT       = int'(DEFAULT_CFG.output_shift)
) (
    input  logic                                  clk,
    input  logic                                  arst_n,
    input  logic                                  start,
    output logic                                  running,
    inout  wire  [DATA_WIDTH-1:0]                 con_1,
    inout  wire  [DATA_WIDTH-1:0]                 con_2,
    inout  wire  [DATA_WIDTH-1:0]                 con_3,
    input  logic                                  con_valid,
    output logic                                  con_ready,
    output logic                                  dut_driving_cons,
    output logic                                  output_valid,
    output logic [$clog2(FEATURE_MAP_WIDTH)-1:0]  output_x,
    output logic [$clog2(FEATURE_MAP_HEIGHT)-1:0] output_y,
    output logic [$clog2(OUTPUT_NB_CHANNELS)-1:0] output_ch
);

    localparam int IC_W = (INPUT_NB_CHANNELS > 1) ? $clog2(INPUT_NB_CHANNELS) : 1;
    localparam int OC_W = $clog2(OUTPUT_NB_CHANNELS);
    localparam int X_W  = $clog2(FEATURE_MAP_WIDTH);
    localparam int Y_W  = $clog2(FEATURE_MAP_HEIGHT);

    localparam logic [1:0]      KY_LAST  = 2'(KERNEL_SIZE - 1);
    localparam logic [IC_W-1:0] ICH_LAST = IC_W'(INPUT_NB_CHANNELS - 1);
    localparam logic [OC_W-1:0] OCH_LAST = OC_W'(OUTPUT_NB_CHANNELS - 1);
    localparam logic [X_W-1:0]  X_LAST   = X_W'(FEATURE_MAP_WIDTH - 1);
    localparam logic [Y_W-1:0]  Y_LAST   = Y_W'(FEATURE_MAP_HEIGHT - 1);

    state_t            state_q, state_d;
    logic [1:0]        ky_q, ky_d, ky_nx_s;
    logic [IC_W-1:0]   ich_q, ich_d, ich_nx_s;
    logic [OC_W-1:0]   och_q, och_d;
    logic [X_W-1:0]    x_q, x_d;
    logic [Y_W-1:0]    y_q, y_d;
    logic              running_q, running_d;
    logic              con_ready_q, con_ready_d;
    logic              drive_q, drive_d;
    logic              valid_q, valid_d;

    logic              xfer_s;
    logic              last_row_s;
    logic              w_we_s;
    logic              a_we_s;
    logic              mac_clr_s;
    logic              mac_en_s;

    logic signed [DATA_WIDTH-1:0] w_q [OUTPUT_NB_CHANNELS][INPUT_NB_CHANNELS][KERNEL_SIZE][KERNEL_SIZE];
    logic signed [DATA_WIDTH-1:0] a_q [INPUT_NB_CHANNELS][KERNEL_SIZE][KERNEL_SIZE];

    logic signed [ACCUMULATION_WIDTH-1:0] acc_s;
    logic signed [63:0]                   shifted_s;
    logic signed [63:0]                   sat_s;
    logic        [DATA_WIDTH-1:0]         result_s;

    assign xfer_s     = con_valid && con_ready_q;
    assign last_row_s = (ky_q == KY_LAST) && (ich_q == ICH_LAST);
    assign ky_nx_s    = (ky_q == KY_LAST) ? 2'd0 : ky_q + 2'd1;
    assign ich_nx_s   = (ky_q != KY_LAST) ? ich_q :
                        ((ich_q == ICH_LAST) ? '0 : ich_q + IC_W'(1));

    // Next-state, counter advance and strobe decode.
    always_comb begin
        state_d   = state_q;
        ky_d      = ky_q;
        ich_d     = ich_q;
        och_d     = och_q;
        x_d       = x_q;
        y_d       = y_q;
        running_d = running_q;
        w_we_s    = 1'b0;
        a_we_s    = 1'b0;
        mac_clr_s = 1'b0;
        mac_en_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = LOAD_W;
                    running_d = 1'b1;
                    ky_d      = '0;
                    ich_d     = '0;
                    och_d     = '0;
                    x_d       = '0;
                    y_d       = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD_W: begin
                if (xfer_s) begin
                    w_we_s = 1'b1;
                    ky_d   = ky_nx_s;
                    ich_d  = ich_nx_s;
                    if (last_row_s && (och_q == OCH_LAST)) begin
                        och_d   = '0;
                        state_d = LOAD_A;
                    end else if (last_row_s) begin
                        och_d = och_q + OC_W'(1);
                    end else begin
                        och_d = och_q;
                    end
                end else begin
                    state_d = LOAD_W;
                end
            end
            LOAD_A: begin
                if (xfer_s) begin
                    a_we_s = 1'b1;
                    ky_d   = ky_nx_s;
                    ich_d  = ich_nx_s;
                    if (last_row_s) begin
                        och_d     = '0;
                        mac_clr_s = 1'b1;
                        state_d   = COMPUTE;
                    end else begin
                        state_d = LOAD_A;
                    end
                end else begin
                    state_d = LOAD_A;
                end
            end
            COMPUTE: begin
                mac_en_s = 1'b1;
                ky_d     = ky_nx_s;
                ich_d    = ich_nx_s;
                if (last_row_s) begin
                    state_d = OUT;
                end else begin
                    state_d = COMPUTE;
                end
            end
            OUT: begin
                if (och_q != OCH_LAST) begin
                    och_d     = och_q + OC_W'(1);
                    mac_clr_s = 1'b1;
                    state_d   = COMPUTE;
                end else begin
                    och_d = '0;
                    if (x_q != X_LAST) begin
                        x_d     = x_q + X_W'(1);
                        state_d = LOAD_A;
                    end else if (y_q != Y_LAST) begin
                        x_d     = '0;
                        y_d     = y_q + Y_W'(1);
                        state_d = LOAD_A;
                    end else begin
                        x_d       = '0;
                        y_d       = '0;
                        running_d = 1'b0;
                        state_d   = IDLE;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                running_d = 1'b0;
            end
        endcase
        con_ready_d = (state_d == LOAD_W) || (state_d == LOAD_A);
        drive_d     = (state_d == OUT);
        valid_d     = (state_d == OUT);
    end

    // Controller state, counters and registered handshake outputs.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q     <= IDLE;
            ky_q        <= '0;
            ich_q       <= '0;
            och_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            running_q   <= 1'b0;
            con_ready_q <= 1'b0;
            drive_q     <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            ky_q        <= ky_d;
            ich_q       <= ich_d;
            och_q       <= och_d;
            x_q         <= x_d;
            y_q         <= y_d;
            running_q   <= running_d;
            con_ready_q <= con_ready_d;
            drive_q     <= drive_d;
            valid_q     <= valid_d;
        end
    end

    // Weight and window storage; every entry is written before it is read.
    always_ff @(posedge clk) begin
        if (w_we_s) begin
            w_q[och_q][ich_q][ky_q][0] <= con_1;
            w_q[och_q][ich_q][ky_q][1] <= con_2;
            w_q[och_q][ich_q][ky_q][2] <= con_3;
        end
        if (a_we_s) begin
            a_q[ich_q][ky_q][0] <= con_1;
            a_q[ich_q][ky_q][1] <= con_2;
            a_q[ich_q][ky_q][2] <= con_3;
        end
    end

    mac3 #(
        .DATA_WIDTH         (DATA_WIDTH),
        .ACCUMULATION_WIDTH (ACCUMULATION_WIDTH)
    ) u_mac3 (
        .clk    (clk),
        .arst_n (arst_n),
        .clr    (mac_clr_s),
        .en     (mac_en_s),
        .w0     (w_q[och_q][ich_q][ky_q][0]),
        .w1     (w_q[och_q][ich_q][ky_q][1]),
        .w2     (w_q[och_q][ich_q][ky_q][2]),
        .a0     (a_q[ich_q][ky_q][0]),
        .a1     (a_q[ich_q][ky_q][1]),
        .a2     (a_q[ich_q][ky_q][2]),
        .acc    (acc_s)
    );

    // Result path: acc is a register and stays stable for the whole OUT cycle.
    always_comb begin
        shifted_s = 64'(acc_s) >>> OUTPUT_SHIFT;
        sat_s     = sat_signed(shifted_s, DATA_WIDTH);
        result_s  = DATA_WIDTH'(sat_s);
`ifdef RELU_EN
        if (result_s[DATA_WIDTH-1]) begin
            result_s = '0;
        end else begin
            result_s = DATA_WIDTH'(sat_s);
        end
`else
        result_s = DATA_WIDTH'(sat_s);
`endif
    end

    assign con_1 = drive_q ? result_s : {DATA_WIDTH{1'bz}};
    assign con_2 = drive_q ? {DATA_WIDTH{1'b0}} : {DATA_WIDTH{1'bz}};
    assign con_3 = drive_q ? {DATA_WIDTH{1'b0}} : {DATA_WIDTH{1'bz}};

    assign running          = running_q;
    assign con_ready        = con_ready_q;
    assign dut_driving_cons = drive_q;
    assign output_valid     = valid_q;
    assign output_x         = x_q;
    assign output_y         = y_q;
    assign output_ch        = och_q;

endmodule

// File: tb/tb_modport_dut.sv
// Directed, table-driven bench for modport_dut (default build, RELU_EN undefined).
module tb_modport_dut;

    localparam int OC = 4;
    localparam int IC = 2;
    localparam int FW = 4;
    localparam int FH = 4;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        start = 1'b0;
    logic        con_valid = 1'b0;
    logic        host_en = 1'b0;
    logic [15:0] h1 = 16'd0;
    logic [15:0] h2 = 16'd0;
    logic [15:0] h3 = 16'd0;
    wire  [15:0] con_1;
    wire  [15:0] con_2;
    wire  [15:0] con_3;
    logic        running;
    logic        con_ready;
    logic        dut_driving_cons;
    logic        output_valid;
    logic [1:0]  output_x;
    logic [1:0]  output_y;
    logic [1:0]  output_ch;

    int cmp_cnt = 0;
    int err_cnt = 0;
    int pulse_cnt = 0;

    assign con_1 = host_en ? h1 : 16'bz;
    assign con_2 = host_en ? h2 : 16'bz;
    assign con_3 = host_en ? h3 : 16'bz;

    modport_dut dut (
        .clk              (clk),
        .arst_n           (arst_n),
        .start            (start),
        .running          (running),
        .con_1            (con_1),
        .con_2            (con_2),
        .con_3            (con_3),
        .con_valid        (con_valid),
        .con_ready        (con_ready),
        .dut_driving_cons (dut_driving_cons),
        .output_valid     (output_valid),
        .output_x         (output_x),
        .output_y         (output_y),
        .output_ch        (output_ch)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (output_valid) pulse_cnt <= pulse_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cmp=%0d err=%0d)", cmp_cnt, err_cnt);
        $fatal(1, "watchdog");
    end

    typedef struct {
        int wmode;        // 0 zero, 1 centre tap, 2 all 127, 3 all -127, 4 all 1
        int amode;        // 0 centre 7 + random, 1 centre 7/-5 per channel + random, 2 all 127, 3 all 2
        int gap;          // idle cycles between transfers
        int extra_start;  // pulse start while running
        int exp_even;     // expected con_1 for even output channels
        int exp_odd;      // expected con_1 for odd output channels
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input int act, input int exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [15:0] wval(input int mode, input int och, input int ich,
                                         input int ky, input int kx);
        case (mode)
            1:       return (ich == och % 2 && ky == 1 && kx == 1) ? 16'd1 : 16'd0;
            2:       return 16'd127;
            3:       return 16'hff81;
            4:       return 16'd1;
            default: return 16'd0;
        endcase
    endfunction

    function automatic logic [15:0] aval(input int mode, input int ich, input int ky, input int kx);
        logic centre;
        centre = (ky == 1 && kx == 1);
        case (mode)
            0:       return centre ? 16'd7 : 16'($urandom);
            1:       return centre ? ((ich == 0) ? 16'd7 : 16'hfffb) : 16'($urandom);
            2:       return 16'd127;
            3:       return 16'd2;
            default: return 16'd0;
        endcase
    endfunction

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // One handshake transfer; optional idle gap during which con_ready must hold.
    task automatic send(input logic [15:0] d1, input logic [15:0] d2, input logic [15:0] d3,
                        input int gap, input bit mid);
        int n;
        @(negedge clk);
        host_en   = 1'b1;
        h1        = d1;
        h2        = d2;
        h3        = d3;
        con_valid = 1'b1;
        n = 0;
        while (!con_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("con_ready_wait", int'(con_ready), 1);
        @(posedge clk);
        #1 con_valid = 1'b0;
        if (mid) begin
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                chk("ready_in_gap", int'(con_ready), 1);
                @(posedge clk);
            end
        end
    endtask

    task automatic load_weights(input int wmode, input int gap);
        for (int o = 0; o < OC; o++)
            for (int i = 0; i < IC; i++)
                for (int ky = 0; ky < 3; ky++)
                    send(wval(wmode, o, i, ky, 0), wval(wmode, o, i, ky, 1), wval(wmode, o, i, ky, 2),
                         gap, !(o == OC - 1 && i == IC - 1 && ky == 2));
    endtask

    task automatic run_layer(input vec_t v);
        int n;
        int base;
        base = pulse_cnt;
        pulse_start();
        chk("running_after_start", int'(running), 1);
        load_weights(v.wmode, v.gap);
        if (v.extra_start != 0) begin
            pulse_start();
            chk("running_after_extra_start", int'(running), 1);
        end
        for (int y = 0; y < FH; y++) begin
            for (int x = 0; x < FW; x++) begin
                for (int i = 0; i < IC; i++)
                    for (int ky = 0; ky < 3; ky++)
                        send(aval(v.amode, i, ky, 0), aval(v.amode, i, ky, 1), aval(v.amode, i, ky, 2),
                             v.gap, !(i == IC - 1 && ky == 2));
                host_en = 1'b0;
                for (int o = 0; o < OC; o++) begin
                    n = 0;
                    do begin
                        @(negedge clk);
                        n++;
                    end while (!output_valid && n < 64);
                    chk("pulse_seen", int'(output_valid), 1);
                    chk("con_1_result", int'($signed(con_1)), (o % 2 == 0) ? v.exp_even : v.exp_odd);
                    chk("con_2_3_zero", int'(con_2 | con_3), 0);
                    chk("coord_yxch", int'({output_y, output_x, output_ch}), (y << 4) | (x << 2) | o);
                    chk("driving_in_out", int'(dut_driving_cons), 1);
                end
            end
        end
        @(negedge clk);
        chk("running_low_after_layer", int'(running), 0);
        chk("driving_low_after_layer", int'(dut_driving_cons), 0);
        @(negedge clk);
        chk("pulse_count", pulse_cnt - base, FW * FH * OC);
    endtask

    initial begin
        vecs[0] = '{wmode: 0, amode: 0, gap: 0, extra_start: 0, exp_even: 0,      exp_odd: 0};
        vecs[1] = '{wmode: 1, amode: 0, gap: 0, extra_start: 0, exp_even: 7,      exp_odd: 7};
        vecs[2] = '{wmode: 1, amode: 1, gap: 0, extra_start: 0, exp_even: 7,      exp_odd: -5};
        vecs[3] = '{wmode: 2, amode: 2, gap: 0, extra_start: 0, exp_even: 32767,  exp_odd: 32767};
        vecs[4] = '{wmode: 3, amode: 2, gap: 0, extra_start: 0, exp_even: -32768, exp_odd: -32768};
        vecs[5] = '{wmode: 1, amode: 1, gap: 3, extra_start: 0, exp_even: 7,      exp_odd: -5};
        vecs[6] = '{wmode: 4, amode: 3, gap: 0, extra_start: 1, exp_even: 36,     exp_odd: 36};

        repeat (3) @(negedge clk);
        chk("reset_running", int'(running), 0);
        chk("reset_con_ready", int'(con_ready), 0);
        chk("reset_output_valid", int'(output_valid), 0);
        chk("reset_driving", int'(dut_driving_cons), 0);
        chk("reset_coords", int'({output_y, output_x, output_ch}), 0);
        arst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int k = 0; k < 7; k++) run_layer(vecs[k]);

        // Abort in the middle of LOAD_A, then restart with fresh weights.
        pulse_start();
        load_weights(4, 0);
        for (int ky = 0; ky < 3; ky++) send(16'd2, 16'd2, 16'd2, 0, 1'b1);
        @(negedge clk);
        host_en = 1'b0;
        arst_n  = 1'b0;
        #1;
        chk("abort_running", int'(running), 0);
        chk("abort_con_ready", int'(con_ready), 0);
        chk("abort_output_valid", int'(output_valid), 0);
        chk("abort_driving", int'(dut_driving_cons), 0);
        chk("abort_coords", int'({output_y, output_x, output_ch}), 0);
        @(negedge clk);
        arst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("abort_idle_no_ready", int'(con_ready), 0);
        run_layer(vecs[2]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
